// File: rtl/meas_ascii_writer_pkg.sv
// Shared constants and types for the measurement ASCII line writer.
// Line layout: "CH" + channel char + ':' + decimal digits + end-of-line byte.
package meas_ascii_writer_pkg;

  localparam logic [7:0] CHR_C     = 8'h43;
  localparam logic [7:0] CHR_H     = 8'h48;
  localparam logic [7:0] CHR_COLON = 8'h3A;
  localparam logic [7:0] CHR_SPACE = 8'h20;
  localparam logic [7:0] CHR_ZERO  = 8'h30;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_ONE   = 8'h31;
  localparam logic [7:0] CHR_TWO   = 8'h32;

  localparam int unsigned DIGITS_DFLT = 6;
  localparam int unsigned FRAME_LEN   = DIGITS_DFLT + 5;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_e;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: load latches bin, then VAL_W shift cycles.
// ready is high during the cycle whose clock edge performs the final shift.
module bin2bcd_seq #(
  parameter int unsigned VAL_W  = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [VAL_W-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ready
);

  localparam int unsigned BCD_W = DIGITS * 4;
  localparam int unsigned TOT_W = BCD_W + VAL_W;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  logic [BCD_W-1:0] r_bcd;
  logic [VAL_W-1:0] r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [BCD_W-1:0] w_adj;
  logic [TOT_W-1:0] w_shift;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  assign w_shift = {w_adj, r_bin} << 1;
  assign ready   = r_active && (r_cnt == CNT_W'(VAL_W - 1));
  assign bcd     = r_bcd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd    <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_bcd    <= '0;
      r_bin    <= bin;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd <= w_shift[TOT_W-1:VAL_W];
      r_bin <= w_shift[VAL_W-1:0];
      r_cnt <= r_cnt + CNT_W'(1);
      if (ready) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/meas_ascii_writer.sv
// Formats one saturated binary measurement as a fixed ASCII line and writes it
// byte-by-byte into the character FIFO, stalling while the FIFO reports full.
module meas_ascii_writer
  import meas_ascii_writer_pkg::*;
#(
  parameter int unsigned VAL_W    = 20,
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned LZ_BLANK = 1,
  parameter logic [7:0]  EOL_CHAR = CHR_LF
) (
  input  logic             clk50M,
  input  logic             reset_n,
  input  logic             start,
  input  logic             ch_sel,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             drop,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_wr_data
);

  localparam int unsigned     LINE_LEN = DIGITS + 5;
  localparam int unsigned     IDX_W    = $clog2(LINE_LEN);
  localparam longint unsigned SAT_LIM  = pow10(DIGITS) - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  state_e               r_state, w_state_d;
  logic [IDX_W-1:0]     r_idx, w_idx_d;
  logic                 r_ch, r_done, r_drop;
  logic                 w_load, w_ready, w_done_d;
  logic [VAL_W-1:0]     w_bin_sat;
  logic [DIGITS*4-1:0]  w_bcd;
  logic [7:0]           w_digit_chr [DIGITS];
  logic [7:0]           w_frame_byte;

  assign w_bin_sat = (64'(value) > SAT_LIM) ? VAL_W'(SAT_LIM) : value;

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk50M),
    .reset_n (reset_n),
    .load    (w_load),
    .bin     (w_bin_sat),
    .bcd     (w_bcd),
    .ready   (w_ready)
  );

  assign fifo_wr_en = (r_state == EMIT) && !fifo_full;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign drop       = r_drop;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_load    = 1'b0;
    w_done_d  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_state_d = CONV;
        end
      end
      CONV: begin
        if (w_ready) begin
          w_state_d = EMIT;
          w_idx_d   = '0;
        end
      end
      EMIT: begin
        if (fifo_wr_en) begin
          if (r_idx == LAST_IDX) begin
            w_state_d = IDLE;
            w_idx_d   = '0;
            w_done_d  = 1'b1;
          end else begin
            w_idx_d = r_idx + IDX_W'(1);
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ch    <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_done  <= w_done_d;
      r_drop  <= start && (r_state != IDLE);
      if (w_load) r_ch <= ch_sel;
    end
  end

  // A digit is blanked while it and every more-significant digit are zero.
  always_comb begin
    logic       w_lead;
    logic [3:0] w_nib;
    w_lead      = 1'b1;
    w_nib       = 4'd0;
    w_digit_chr = '{default: CHR_SPACE};
    for (int i = 0; i < DIGITS; i++) begin
      w_nib  = w_bcd[(DIGITS-1-i)*4 +: 4];
      w_lead = w_lead && (w_nib == 4'd0);
      if ((LZ_BLANK != 0) && (i != DIGITS - 1) && w_lead) w_digit_chr[i] = CHR_SPACE;
      else                                                  w_digit_chr[i] = CHR_ZERO + {4'h0, w_nib};
    end
  end

  always_comb begin
    w_frame_byte = EOL_CHAR;
    if (r_idx == IDX_W'(0))      w_frame_byte = CHR_C;
    else if (r_idx == IDX_W'(1)) w_frame_byte = CHR_H;
    else if (r_idx == IDX_W'(2)) w_frame_byte = r_ch ? CHR_TWO : CHR_ONE;
    else if (r_idx == IDX_W'(3)) w_frame_byte = CHR_COLON;
    else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (r_idx == IDX_W'(4 + i)) w_frame_byte = w_digit_chr[i];
      end
    end
  end

  assign fifo_wr_data = (r_state == EMIT) ? w_frame_byte : 8'h00;

endmodule
